// File: rtl/wb_pkg.sv
// Shared constants for the write-back selector: source indices, load-size
// encodings and the exception constant the parent wires to source 2.
package wb_pkg;

  localparam int WB_SRC_ALU   = 0;
  localparam int WB_SRC_MDR   = 1;
  localparam int WB_SRC_CONST = 2;
  localparam int WB_SRC_EXC   = 3;
  localparam int WB_SRC_PC    = 4;

  typedef enum logic [1:0] {
    LS_WORD = 2'd0,
    LS_HALF = 2'd1,
    LS_BYTE = 2'd2
  } load_size_e;

  localparam logic [31:0] WB_EXC_CONST = 32'd227;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational byte/half/word extractor with sign or zero extension for the
// memory data register source. Used only when WB_LOAD_EXT_EN is defined.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       load_size,
  input  logic             load_signed,
  output logic [WIDTH-1:0] dout
);

  // Encoding 3 is unassigned and falls through to a full-word pass.
  always_comb begin
    dout = din;
    case (load_size)
      LS_HALF: dout = {{(WIDTH-16){load_signed & din[15]}}, din[15:0]};
      LS_BYTE: dout = {{(WIDTH-8){load_signed & din[7]}}, din[7:0]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/wb_select_unit.sv
// Registered write-back source selector with ready/request handshake and stall
// hold. Define WB_LOAD_EXT_EN to add load byte/half extension on source 1.
module wb_select_unit
  import wb_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               NSRC        = 5,
  parameter int               SEL_W       = 3,
  parameter int               DST_W       = 5,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NSRC*WIDTH-1:0] src_flat,
  input  logic [DST_W-1:0]      wb_dst,
  input  logic                  wb_req,
  input  logic                  wb_stall,
`ifdef WB_LOAD_EXT_EN
  input  logic [1:0]            load_size,
  input  logic                  load_signed,
`endif
  output logic                  wb_ready,
  output logic [WIDTH-1:0]      wb_data,
  output logic [DST_W-1:0]      wb_addr,
  output logic                  wb_we,
  output logic                  sel_err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [DST_W-1:0] addr_reg, addr_next;
  logic             sel_err_reg, sel_err_next;

  logic [WIDTH-1:0] src_arr [NSRC];
  logic [WIDTH-1:0] sel_val;
  logic             sel_hit;

`ifdef WB_LOAD_EXT_EN
  logic [WIDTH-1:0] mdr_ext;

  wb_load_ext #(.WIDTH(WIDTH)) u_load_ext (
    .din         (src_flat[WB_SRC_MDR*WIDTH +: WIDTH]),
    .load_size   (load_size),
    .load_signed (load_signed),
    .dout        (mdr_ext)
  );
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
`ifdef WB_LOAD_EXT_EN
      if (gi == WB_SRC_MDR) begin : g_mdr
        assign src_arr[gi] = mdr_ext;
      end else begin : g_raw
        assign src_arr[gi] = src_flat[gi*WIDTH +: WIDTH];
      end
`else
      assign src_arr[gi] = src_flat[gi*WIDTH +: WIDTH];
`endif
    end
  endgenerate

  // Out-of-range codes leave sel_hit low so DEFAULT_VAL is captured.
  always_comb begin
    sel_val = DEFAULT_VAL;
    sel_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_val = src_arr[i];
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    addr_next    = addr_reg;
    sel_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wb_req) begin
          data_next    = sel_val;
          addr_next    = wb_dst;
          sel_err_next = !sel_hit;
          state_next   = WRITE;
        end
      end
      default: begin
        if (!wb_stall) begin
          if (wb_req) begin
            data_next    = sel_val;
            addr_next    = wb_dst;
            sel_err_next = !sel_hit;
          end else begin
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      data_reg    <= '0;
      addr_reg    <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      addr_reg    <= addr_next;
      sel_err_reg <= sel_err_next;
    end
  end

  // Strobe is masked by reset so a write pending at reset is dropped.
  assign wb_ready = (state_reg == IDLE) || !wb_stall;
  assign wb_we    = (state_reg == WRITE) && !wb_stall && (addr_reg != '0) && !reset;
  assign wb_data  = data_reg;
  assign wb_addr  = addr_reg;
  assign sel_err  = sel_err_reg;

endmodule

// File: tb/tb_wb_select_unit.sv
// Directed bench for wb_select_unit: vector table of single transactions plus
// stall, back-to-back and reset-during-write sequences.
module tb_wb_select_unit;

  localparam int WIDTH = 32;
  localparam int NSRC  = 5;
  localparam int SEL_W = 3;
  localparam int DST_W = 5;

  localparam logic [31:0] S0 = 32'h0000_1234;
  localparam logic [31:0] S1 = 32'h0000_80F0;
  localparam logic [31:0] S2 = 32'd227;
  localparam logic [31:0] S3 = 32'hDEAD_BEEF;
  localparam logic [31:0] S4 = 32'h0040_0010;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [SEL_W-1:0]      sel;
  logic [NSRC*WIDTH-1:0] src_flat;
  logic [DST_W-1:0]      wb_dst;
  logic                  wb_req;
  logic                  wb_stall;
  logic                  wb_ready;
  logic [WIDTH-1:0]      wb_data;
  logic [DST_W-1:0]      wb_addr;
  logic                  wb_we;
  logic                  sel_err;
`ifdef WB_LOAD_EXT_EN
  logic [1:0]            load_size;
  logic                  load_signed;
`endif

  always #5 clk = ~clk;

  wb_select_unit #(
    .WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W), .DST_W(DST_W), .DEFAULT_VAL('0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .src_flat    (src_flat),
    .wb_dst      (wb_dst),
    .wb_req      (wb_req),
    .wb_stall    (wb_stall),
`ifdef WB_LOAD_EXT_EN
    .load_size   (load_size),
    .load_signed (load_signed),
`endif
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_addr     (wb_addr),
    .wb_we       (wb_we),
    .sel_err     (sel_err)
  );

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic [4:0]  dst;
    logic [1:0]  lsize;
    logic        lsigned;
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input logic [2:0] s, input logic [4:0] d,
                         input logic [1:0] ls, input logic lsg, input logic [31:0] ed,
                         input logic ew, input logic ee);
    vec_t v;
    v.name = name; v.sel = s; v.dst = d; v.lsize = ls; v.lsigned = lsg;
    v.exp_data = ed; v.exp_we = ew; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk_write(input string name, input logic [31:0] d, input logic [4:0] a);
    chk({name, " we"},   32'(wb_we), 32'(1));
    chk({name, " data"}, wb_data, d);
    chk({name, " addr"}, 32'(wb_addr), 32'(a));
  endtask

  initial begin
    add_vec("alu",       3'd0, 5'd8,  2'd0, 1'b0, S0,    1'b1, 1'b0);
    add_vec("mdr",       3'd1, 5'd9,  2'd0, 1'b0, S1,    1'b1, 1'b0);
    add_vec("const",     3'd2, 5'd31, 2'd0, 1'b0, S2,    1'b1, 1'b0);
    add_vec("exc",       3'd3, 5'd1,  2'd0, 1'b0, S3,    1'b1, 1'b0);
    add_vec("pc_r0",     3'd4, 5'd0,  2'd0, 1'b0, S4,    1'b0, 1'b0);
    add_vec("sel5",      3'd5, 5'd12, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    add_vec("sel6",      3'd6, 5'd5,  2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    add_vec("sel7",      3'd7, 5'd3,  2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
`ifdef WB_LOAD_EXT_EN
    add_vec("byte_s",    3'd1, 5'd7,  2'd2, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0);
    add_vec("byte_u",    3'd1, 5'd7,  2'd2, 1'b0, 32'h0000_00F0, 1'b1, 1'b0);
    add_vec("half_u",    3'd1, 5'd7,  2'd1, 1'b0, 32'h0000_80F0, 1'b1, 1'b0);
    add_vec("half_s",    3'd1, 5'd7,  2'd1, 1'b1, 32'hFFFF_80F0, 1'b1, 1'b0);
    add_vec("size3_s",   3'd1, 5'd7,  2'd3, 1'b1, 32'h0000_80F0, 1'b1, 1'b0);
    add_vec("alu_byte",  3'd0, 5'd6,  2'd2, 1'b1, S0,            1'b1, 1'b0);
`endif

    reset = 1'b1; wb_req = 1'b0; wb_stall = 1'b0; sel = '0; wb_dst = '0;
    src_flat = {S4, S3, S2, S1, S0};
`ifdef WB_LOAD_EXT_EN
    load_size = 2'd0; load_signed = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset ready", 32'(wb_ready), 32'(1));
    chk("reset we",    32'(wb_we),    32'(0));
    chk("reset data",  wb_data,       32'h0);
    chk("reset addr",  32'(wb_addr),  32'(0));
    chk("reset err",   32'(sel_err),  32'(0));

    foreach (vecs[i]) begin
      sel = vecs[i].sel; wb_dst = vecs[i].dst; wb_req = 1'b1;
`ifdef WB_LOAD_EXT_EN
      load_size = vecs[i].lsize; load_signed = vecs[i].lsigned;
`endif
      tick();
      wb_req = 1'b0; sel = '0; wb_dst = '0;
      $display("vec %s sel=%0d dst=%0d -> data=0x%08h addr=%0d we=%0b err=%0b",
               vecs[i].name, vecs[i].sel, vecs[i].dst, wb_data, wb_addr, wb_we, sel_err);
      chk({vecs[i].name, " data"}, wb_data, vecs[i].exp_data);
      chk({vecs[i].name, " addr"}, 32'(wb_addr), 32'(vecs[i].dst));
      chk({vecs[i].name, " we"},   32'(wb_we), 32'(vecs[i].exp_we));
      chk({vecs[i].name, " err"},  32'(sel_err), 32'(vecs[i].exp_err));
      tick();
      chk({vecs[i].name, " idle ready"}, 32'(wb_ready), 32'(1));
      chk({vecs[i].name, " idle we"},    32'(wb_we), 32'(0));
      chk({vecs[i].name, " err pulse"},  32'(sel_err), 32'(0));
    end
`ifdef WB_LOAD_EXT_EN
    load_size = 2'd0; load_signed = 1'b0;
`endif

    // Stall for three cycles with a second request pending.
    sel = 3'd0; wb_dst = 5'd8; wb_req = 1'b1;
    tick();
    sel = 3'd3; wb_dst = 5'd4; wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      $display("stall cycle %0d: we=%0b ready=%0b data=0x%08h addr=%0d", c, wb_we, wb_ready, wb_data, wb_addr);
      chk($sformatf("stall%0d we", c),    32'(wb_we), 32'(0));
      chk($sformatf("stall%0d ready", c), 32'(wb_ready), 32'(0));
      chk($sformatf("stall%0d data", c),  wb_data, S0);
      chk($sformatf("stall%0d addr", c),  32'(wb_addr), 32'(8));
      tick();
    end
    wb_stall = 1'b0;
    #1;
    $display("stall release: we=%0b data=0x%08h addr=%0d", wb_we, wb_data, wb_addr);
    chk("release ready", 32'(wb_ready), 32'(1));
    chk_write("release", S0, 5'd8);
    tick();
    wb_req = 1'b0;
    $display("pending accepted: we=%0b data=0x%08h addr=%0d", wb_we, wb_data, wb_addr);
    chk_write("pending", S3, 5'd4);
    tick();
    chk("post stall idle we", 32'(wb_we), 32'(0));

    // Back-to-back requests, one write per cycle.
    for (int i = 0; i < 4; i++) begin
      sel = 3'(i); wb_dst = 5'(10 + i); wb_req = 1'b1;
      if (i > 0) begin
        #1;
        $display("b2b write %0d: we=%0b data=0x%08h addr=%0d", i - 1, wb_we, wb_data, wb_addr);
        chk_write($sformatf("b2b%0d", i - 1), src_flat[(i-1)*32 +: 32], 5'(9 + i));
      end
      tick();
    end
    wb_req = 1'b0;
    $display("b2b write 3: we=%0b data=0x%08h addr=%0d", wb_we, wb_data, wb_addr);
    chk_write("b2b3", S3, 5'd13);
    tick();
    chk("b2b idle we", 32'(wb_we), 32'(0));

    // Reset while a write is pending.
    sel = 3'd0; wb_dst = 5'd8; wb_req = 1'b1;
    tick();
    wb_req = 1'b0; reset = 1'b1;
    #1;
    $display("reset in WRITE: we=%0b", wb_we);
    chk("rst write we", 32'(wb_we), 32'(0));
    tick();
    reset = 1'b0;
    #1;
    chk("rst after ready", 32'(wb_ready), 32'(1));
    chk("rst after we",    32'(wb_we), 32'(0));
    chk("rst after data",  wb_data, 32'h0);
    chk("rst after addr",  32'(wb_addr), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_select_unit.md
Name: wb_select_unit

Overview:
- Parametrised, registered write-back source selector for the multicycle datapath's register-bank write port.
- Picks one of NSRC data sources (ALU out, memory data register, constant, exception address, PC, ...) with a select code and captures the result with its destination register index.
- Drives a single-cycle write strobe with a ready/request handshake and a stall hold.
- Sits between the datapath sources and the register bank; the control FSM is its only requester.

Parameters:
- WIDTH, 32, data width of every source and of the output.
- NSRC, 5, number of selectable sources (2..8).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NSRC.
- DST_W, 5, register index width.
- DEFAULT_VAL, 0, value captured when sel >= NSRC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  SEL_W  source select code.
- src_flat  in  NSRC*WIDTH  concatenated sources; source i occupies bits [i*WIDTH +: WIDTH].
- wb_dst  in  DST_W  destination register index.
- wb_req  in  1  request to capture the selected source.
- wb_stall  in  1  register bank busy; hold the pending write.
- wb_ready  out  1  unit can accept wb_req this cycle.
- wb_data  out  WIDTH  captured write data.
- wb_addr  out  DST_W  captured destination index.
- wb_we  out  1  register-bank write strobe.
- sel_err  out  1  one-cycle pulse when an out-of-range sel is accepted.
- load_size  in  2  0 = word, 1 = half, 2 = byte. Present only with WB_LOAD_EXT_EN.
- load_signed  in  1  sign-extend (1) or zero-extend (0). Present only with WB_LOAD_EXT_EN.

Behaviour:
- Reset: the synchronous, active-high reset is the decided fact for this block; clock port is clk, reset port is reset. The FSM goes to IDLE and every output is 0, except wb_ready = 1.
- Reset mid-WRITE: the pending write is dropped and no wb_we is issued.
- FSM has two states, IDLE and WRITE.
- IDLE:
  - wb_ready = 1, wb_we = 0.
  - On wb_req: capture mux(sel) into wb_data and wb_dst into wb_addr, then go to WRITE.
- Acceptance latency: data and address are visible on the outputs the cycle after acceptance.
- WRITE:
  - wb_we = !wb_stall && (wb_addr != 0).
  - Register 0 is never written, but the transaction still completes.
  - wb_ready = !wb_stall.
  - While wb_stall = 1: hold wb_data and wb_addr, stay in WRITE, and ignore wb_req.
  - When wb_stall = 0 and wb_req = 1: complete the current write this cycle, capture the new request and stay in WRITE (back-to-back, one write per cycle).
  - When wb_stall = 0 and wb_req = 0: go to IDLE.
- Select rule: sel < NSRC picks source sel; otherwise DEFAULT_VAL is captured and sel_err pulses for one cycle, aligned with the output update.
- sel, src_flat and wb_dst are sampled only on the accepting edge.
- Selection is purely combinational before the capture register; no arithmetic beyond the optional extension.

Optional Feature:
- WB_LOAD_EXT_EN defined:
  - Adds the load_size and load_signed ports.
  - When sel = 1 (memory data register), the selected source is byte/half/word extracted from bits [7:0] or [15:0], then sign- or zero-extended to WIDTH before capture.
  - load_size = 3 is treated as word.
  - Other sources are unaffected.
- WB_LOAD_EXT_EN undefined: those ports are absent and source 1 passes through unchanged.

Decomposition:
- Shared package wb_pkg holds:
  - source index constants WB_SRC_ALU = 0, WB_SRC_MDR = 1, WB_SRC_CONST = 2, WB_SRC_EXC = 3, WB_SRC_PC = 4;
  - load-size encodings LS_WORD, LS_HALF, LS_BYTE;
  - the exception constant 227, which the parent wires to source 2.
- One sub-module, wb_load_ext, holds the combinational extender and is instantiated only under the macro.

Test Plan:
- Reset then idle: wb_ready = 1, wb_we = 0, wb_data = 0, wb_addr = 0.
- sel = 0, ALU = 0x0000_1234, dst = 8, wb_req for one cycle: next cycle wb_we = 1, wb_data = 0x1234, wb_addr = 8; the cycle after, IDLE.
- wb_stall = 1 for 3 cycles during WRITE with a new wb_req pending: wb_we = 0 and data is held; on stall release, one write occurs, then the new request is accepted.
- sel = 6 with NSRC = 5: wb_data = 0 and sel_err pulses once; dst = 0 with sel = 4 completes with wb_we never asserted.
- Back-to-back: wb_req on 4 consecutive cycles, sel = 0..3, no stall: 4 consecutive wb_we pulses with matching data and addresses.
- WB_LOAD_EXT_EN, sel = 1, MDR = 0x0000_80F0:
  - load_size = byte, signed: 0xFFFF_FFF0.
  - load_size = half, unsigned: 0x0000_80F0.
  - load_size = half, signed: 0xFFFF_80F0.
